id_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the decode stage. It decides each cycle whether the PC, IF/ID and ID/EX registers hold, flush or advance.
- Detects load-use hazards between the decode instruction and a load in EX.
- Freezes the pipeline while data memory is busy.
- Applies branch/jump flushes, deferring them if they arrive during a freeze.
- Keeps saturating stall/flush performance counters.

---
 rtl/id_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_id_hazard_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// id_hazard_ctrl
//
// Decode-stage sequencing controller. Each cycle it decides whether the PC,
// IF/ID and ID/EX registers hold, flush or advance.
//
// The conditions are checked in this order:
//   freeze    data memory busy. The whole front end holds. A redirect that
//             arrives during the freeze is remembered, not applied.
//   flush     a redirect from EX, or a remembered one. IF/ID and ID/EX are
//             cleared.
//   load-use  the decode instruction reads the register that the load now
//             in EX writes. One bubble goes into ID/EX.
//   run       everything advances.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   id_*            decode instruction: valid, source registers with their
//                   use flags, load flag, destination register
//   ex_redirect     branch taken or jump resolved in EX (one-cycle pulse)
//   mem_busy        data memory not ready; MEM stage cannot complete
//   pc_stall, ifid_stall, idex_stall      hold controls
//   ifid_flush, idex_flush                bubble-insert controls
//   stall_cnt       saturating count of cycles with pc_stall=1
//   flush_cnt       saturating count of flush events applied
// ----------------------------------------------------------------------------
module id_hazard_ctrl #(
   parameter int CNT_WIDTH      = 16,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      id_valid,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
   input  logic                      id_uses_rs1,
   input  logic                      id_uses_rs2,
   input  logic                      id_MemRead,
   input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
   input  logic                      ex_redirect,
   input  logic                      mem_busy,
   output logic                      pc_stall,
   output logic                      ifid_stall,
   output logic                      ifid_flush,
   output logic                      idex_stall,
   output logic                      idex_flush,
   output logic [CNT_WIDTH-1:0]      stall_cnt,
   output logic [CNT_WIDTH-1:0]      flush_cnt
);

   localparam logic [CNT_WIDTH-1:0]      CNT_ONE = 1;
   localparam logic [REG_ADDR_WIDTH-1:0] REG_X0  = '0;

   // Shadow of the load now in EX, plus a redirect that was held back
   // by a freeze.
   logic                      ex_load;
   logic [REG_ADDR_WIDTH-1:0] ex_rd;
   logic                      pend_flush;

   logic freeze;
   logic do_flush;
   logic rs1_hit;
   logic rs2_hit;
   logic load_use;

   // Performance counters stop at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (&v) return v;
      else    return v + CNT_ONE;
   endfunction

   // Combinational decision: zero-cycle latency from inputs to controls
   always_comb begin
      freeze   = mem_busy;
      do_flush = !mem_busy && (ex_redirect || pend_flush);
      rs1_hit  = id_uses_rs1 && (id_rs1_addr == ex_rd);
      rs2_hit  = id_uses_rs2 && (id_rs2_addr == ex_rd);
      // A flush wins over a hazard: the younger instruction is discarded.
      load_use = !freeze && !do_flush && id_valid && ex_load &&
                 (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      idex_stall = 1'b0;
      idex_flush = 1'b0;

      if (!rst_n) begin
         // While reset is held, both pipeline registers are cleared.
         // Any stall in progress is dropped in the same cycle.
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (freeze) begin
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
         idex_stall = 1'b1;
      end else if (do_flush) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use) begin
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
         idex_flush = 1'b1;
      end
   end

   // State update at the clock edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_load    <= 1'b0;
         ex_rd      <= '0;
         pend_flush <= 1'b0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
      end else begin
         if (freeze) begin
            // ex_load and ex_rd hold. Many redirects during one freeze
            // still produce a single flush.
            if (ex_redirect) pend_flush <= 1'b1;
         end else if (do_flush) begin
            pend_flush <= 1'b0;
            ex_load    <= 1'b0;
            flush_cnt  <= sat_inc(flush_cnt);
         end else if (load_use) begin
            // The bubble now in EX is not a load. This limits each hazard
            // to exactly one bubble.
            ex_load <= 1'b0;
         end else begin
            ex_load <= id_valid && id_MemRead && (id_rd_addr != REG_X0);
            ex_rd   <= id_rd_addr;
         end

         if (pc_stall) stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
module tb_id_hazard_ctrl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rs1_addr;
   logic [4:0] id_rs2_addr;
   logic       id_uses_rs1;
   logic       id_uses_rs2;
   logic       id_MemRead;
   logic [4:0] id_rd_addr;
   logic       ex_redirect;
   logic       mem_busy;

   logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
   logic [15:0] stall_cnt, flush_cnt;
   logic        s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_stall, s_idex_flush;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   id_hazard_ctrl #(.CNT_WIDTH(16), .REG_ADDR_WIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_MemRead(id_MemRead), .id_rd_addr(id_rd_addr),
      .ex_redirect(ex_redirect), .mem_busy(mem_busy),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_stall(idex_stall), .idex_flush(idex_flush),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Narrow-counter instance for the saturation checks.
   id_hazard_ctrl #(.CNT_WIDTH(4), .REG_ADDR_WIDTH(5)) dut_sat (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_MemRead(id_MemRead), .id_rd_addr(id_rd_addr),
      .ex_redirect(ex_redirect), .mem_busy(mem_busy),
      .pc_stall(s_pc_stall), .ifid_stall(s_ifid_stall), .ifid_flush(s_ifid_flush),
      .idex_stall(s_idex_stall), .idex_flush(s_idex_flush),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush}
   localparam logic [4:0] C_RUN = 5'b00000;
   localparam logic [4:0] C_FRZ = 5'b11010;
   localparam logic [4:0] C_FLS = 5'b00101;
   localparam logic [4:0] C_LU  = 5'b11001;
   localparam logic [4:0] C_RST = 5'b00101;

   typedef struct {
      string      tag;
      logic [4:0] ctl;
      int         stall;
      int         flush;
      int         sstall;
      int         sflush;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // Expected counter values. They are derived from the hand-written
   // control expectations.
   int m_stall = 0, m_flush = 0, m_sstall = 0, m_sflush = 0;

   task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s/%s actual=%0h required=%0h", tag, name, act, req);
      end
   endtask

   // Drive one cycle of stimulus and queue the response expected in that cycle.
   task automatic step(input string tag, input logic r, input logic v,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic mr, input logic [4:0] rd,
                       input logic redir, input logic busy,
                       input logic [4:0] ctl);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n       = r;
      id_valid    = v;
      id_rs1_addr = rs1;
      id_uses_rs1 = u1;
      id_rs2_addr = rs2;
      id_uses_rs2 = u2;
      id_MemRead  = mr;
      id_rd_addr  = rd;
      ex_redirect = redir;
      mem_busy    = busy;
      e.tag = tag; e.ctl = ctl;
      e.stall = m_stall; e.flush = m_flush; e.sstall = m_sstall; e.sflush = m_sflush;
      sb.push_back(e);
      if (!r) begin
         m_stall = 0; m_flush = 0; m_sstall = 0; m_sflush = 0;
      end else begin
         if (ctl[4]) begin
            if (m_stall < 65535) m_stall++;
            if (m_sstall < 15) m_sstall++;
         end
         if (ctl[2]) begin
            if (m_flush < 65535) m_flush++;
            if (m_sflush < 15) m_sflush++;
         end
      end
   endtask

   task automatic idle(input string tag, input logic busy, input logic redir, input logic [4:0] ctl);
      step(tag, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, redir, busy, ctl);
   endtask

   // Monitor: outputs are present every cycle, so each queued expectation is
   // compared mid-cycle, away from the active edge.
   exp_t mon_e;
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         chk("ctl", mon_e.tag, {27'd0, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush}, {27'd0, mon_e.ctl});
         chk("stall_cnt", mon_e.tag, {16'd0, stall_cnt}, mon_e.stall);
         chk("flush_cnt", mon_e.tag, {16'd0, flush_cnt}, mon_e.flush);
         chk("sat_stall_cnt", mon_e.tag, {28'd0, s_stall_cnt}, mon_e.sstall);
         chk("sat_flush_cnt", mon_e.tag, {28'd0, s_flush_cnt}, mon_e.sflush);
      end
   end

   initial begin
      rst_n = 1'b0; id_valid = 1'b0; id_rs1_addr = '0; id_rs2_addr = '0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_MemRead = 1'b0;
      id_rd_addr = '0; ex_redirect = 1'b0; mem_busy = 1'b0;

      //   tag       r  v  rs1 u1 rs2 u2 mr rd redir busy ctl
      step("reset0", 0, 0, 0,  0, 0,  0, 0, 0, 0,    0,   C_RST);
      step("reset1", 0, 1, 5,  1, 5,  1, 1, 5, 0,    1,   C_RST);

      // Load then use: one bubble only
      step("lu_load", 1, 1, 0, 0, 0, 0, 1, 5, 0, 0, C_RUN);
      step("lu_use",  1, 1, 5, 1, 0, 0, 0, 6, 0, 0, C_LU);
      step("lu_go",   1, 1, 5, 1, 0, 0, 0, 6, 0, 0, C_RUN);
      idle("lu_idle", 0, 0, C_RUN);

      // x0 load never creates a hazard
      step("x0_load", 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, C_RUN);
      step("x0_use",  1, 1, 0, 1, 0, 1, 0, 7, 0, 0, C_RUN);

      // rs2 field matches but is not used
      step("rs2u_load", 1, 1, 0, 0, 0, 0, 1, 5, 0, 0, C_RUN);
      step("rs2u_use",  1, 1, 3, 0, 5, 0, 0, 8, 0, 0, C_RUN);

      // rs2 used and matching
      step("rs2_load", 1, 1, 0, 0, 0, 0, 1, 7, 0, 0, C_RUN);
      step("rs2_use",  1, 1, 1, 1, 7, 1, 0, 2, 0, 0, C_LU);
      step("rs2_go",   1, 1, 1, 1, 7, 1, 0, 2, 0, 0, C_RUN);

      // Redirect in 2nd of 3 freeze cycles -> deferred single flush
      idle("frz1", 1, 0, C_FRZ);
      idle("frz2", 1, 1, C_FRZ);
      idle("frz3", 1, 0, C_FRZ);
      idle("frz_fl", 0, 0, C_FLS);
      idle("frz_run", 0, 0, C_RUN);

      // Freeze holds the EX load shadow; the hazard appears after it
      step("hold_load", 1, 1, 0, 0, 0, 0, 1, 9, 0, 0, C_RUN);
      step("hold_frz",  1, 1, 9, 1, 0, 0, 0, 4, 0, 1, C_FRZ);
      step("hold_lu",   1, 1, 9, 1, 0, 0, 0, 4, 0, 0, C_LU);
      step("hold_go",   1, 1, 9, 1, 0, 0, 0, 4, 0, 0, C_RUN);

      // Redirect coincident with a load-use hazard -> flush only
      step("rl_load", 1, 1, 0, 0, 0, 0, 1, 4, 0, 0, C_RUN);
      step("rl_both", 1, 1, 4, 1, 0, 0, 0, 6, 1, 0, C_FLS);
      step("rl_after",1, 1, 4, 1, 0, 0, 0, 6, 0, 0, C_RUN);

      // Several redirects in one freeze -> exactly one flush
      idle("mr_frz1", 1, 1, C_FRZ);
      idle("mr_frz2", 1, 1, C_FRZ);
      idle("mr_fl",   0, 0, C_FLS);
      idle("mr_run",  0, 0, C_RUN);

      // Reset mid-freeze drops stalls and discards the pending flush and load
      step("rf_load", 1, 1, 0, 0, 0, 0, 1, 3, 0, 0, C_RUN);
      idle("rf_frz", 1, 1, C_FRZ);
      step("rf_rst",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RST);
      step("rf_use",  1, 1, 3, 1, 0, 0, 0, 2, 0, 0, C_RUN);

      // Stall counter saturation: 20 freeze cycles
      for (int i = 0; i < 20; i++) idle("sat_frz", 1, 0, C_FRZ);
      idle("sat_frz_end", 0, 0, C_RUN);
      idle("sat_frz_hold", 0, 0, C_RUN);

      // Flush counter saturation: 17 back-to-back redirects
      for (int i = 0; i < 17; i++) idle("sat_fl", 0, 1, C_FLS);
      idle("sat_fl_end", 0, 0, C_RUN);
      idle("sat_fl_hold", 0, 0, C_RUN);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
      @(posedge clk);
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain actual=%0d required=0 pending", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
